// File: rtl/sequence_gen.sv
// sequence_gen: serial symbol generator for the two-strobe (zero/one) symbol link.
// Captures up to WIDTH bits on start, then sends them MSB-first as one-cycle
// strobes separated by GAP idle cycles, finishing with a one-cycle done pulse.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-low reset
//   start    - load request, honoured only in IDLE
//   pattern  - symbols to send; bit len-1 goes first, bit 0 last
//   len      - symbol count; values above WIDTH are clamped to WIDTH
//   zero     - one-cycle strobe for a 0 symbol
//   one      - one-cycle strobe for a 1 symbol
//   busy     - high from the cycle after an accepted start through DONE
//   done     - one-cycle completion pulse
module sequence_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             zero,
    output logic             one,
    output logic             busy,
    output logic             done
);

    // Gap counter holds GAP-1 down to 0; keep at least one bit when GAP <= 1.
    localparam int unsigned      GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   sreg, sreg_nxt;
    logic [LEN_W-1:0]   rem, rem_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [LEN_W-1:0]   len_eff;
    logic               zero_nxt, one_nxt, busy_nxt, done_nxt;

    // Next-state, datapath and output decode.
    // Outputs are computed from the next state so the flops present them in the
    // same cycle the state register enters that state.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        rem_nxt   = rem;
        gap_nxt   = gap_cnt;
        len_eff   = (len > WIDTH_L) ? WIDTH_L : len;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len_eff != '0) begin
                        // Left-align so bit len-1 lands in the MSB.
                        sreg_nxt  = pattern << (WIDTH_L - len_eff);
                        rem_nxt   = len_eff;
                        state_nxt = S_EMIT;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_EMIT: begin
                sreg_nxt = sreg << 1;
                rem_nxt  = rem - LEN_W'(1);
                if (rem == LEN_W'(1)) begin
                    state_nxt = S_DONE;
                end else if (GAP > 0) begin
                    gap_nxt   = GAP_LOAD;
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_EMIT;
                end
            end
            S_WAIT: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_EMIT;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        zero_nxt = (state_nxt == S_EMIT) && !sreg_nxt[WIDTH-1];
        one_nxt  = (state_nxt == S_EMIT) &&  sreg_nxt[WIDTH-1];
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            sreg    <= '0;
            rem     <= '0;
            gap_cnt <= '0;
            zero    <= 1'b0;
            one     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            rem     <= rem_nxt;
            gap_cnt <= gap_nxt;
            zero    <= zero_nxt;
            one     <= one_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule
